// File: rtl/cam_capture_if.sv
// Camera pin bundle and captured-pixel outputs of the cam_capture front end.
interface cam_capture_if;
  logic [7:0]  camera_data;
  logic        pclk;
  logic        href;
  logic        vsync;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_x;
  logic [6:0]  pixel_y;
  logic        frame_start;
  logic        frame_done;
  logic        frame_ok;
  logic        overflow;

  // Camera side (sensor model or pad ring) drives the pins and observes results.
  modport master (
    output camera_data, pclk, href, vsync,
    input  pixel_data, pixel_valid, pixel_x, pixel_y,
    input  frame_start, frame_done, frame_ok, overflow
  );

  // Capture stage consumes the pins and produces pixels.
  modport slave (
    input  camera_data, pclk, href, vsync,
    output pixel_data, pixel_valid, pixel_x, pixel_y,
    output frame_start, frame_done, frame_ok, overflow
  );
endinterface

// File: rtl/cam_capture.sv
// OV7670 capture: oversamples camera pins in the clk domain and assembles RGB565 pixels.
module cam_capture #(
  parameter int unsigned IMG_W = 160,
  parameter int unsigned IMG_H = 120
) (
  input logic         clk,
  input logic         reset,
  cam_capture_if.slave cam
);

  localparam logic [8:0] XMax = 9'(IMG_W);
  localparam logic [7:0] YMax = 8'(IMG_H);

  typedef enum logic [1:0] {StWaitFrame, StWaitLine, StByteLo} state_e;

  // [0] first sync flop, [1] synced level, [2] previous synced level
  logic [2:0] pclk_q, href_q, vsync_q;
  logic [7:0] data1_q, data2_q;

  // Registered edge events, aligned with byte_q
  logic       prise_q, hfall_q, vfall_q, vrise_q, href_ev_q;
  logic [7:0] byte_q;

  state_e      state_q;
  logic [7:0]  hi_q;
  logic [8:0]  x_q;      // wide enough to saturate at 256
  logic [7:0]  y_q;      // wide enough to saturate at 128
  logic        inc_q;    // column increment deferred to the cycle after the strobe
  logic [15:0] pixel_data_q;
  logic        pixel_valid_q, frame_start_q, frame_done_q, frame_ok_q, overflow_q;
  logic [8:0]  x_eff;

  assign x_eff = x_q + {8'd0, inc_q};

  // Synchronisers, camera_data delay line and edge-event register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pclk_q    <= '0;
      href_q    <= '0;
      vsync_q   <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      prise_q   <= 1'b0;
      hfall_q   <= 1'b0;
      vfall_q   <= 1'b0;
      vrise_q   <= 1'b0;
      href_ev_q <= 1'b0;
      byte_q    <= '0;
    end else begin
      pclk_q    <= {pclk_q[1:0], cam.pclk};
      href_q    <= {href_q[1:0], cam.href};
      vsync_q   <= {vsync_q[1:0], cam.vsync};
      data1_q   <= cam.camera_data;
      data2_q   <= data1_q;
      prise_q   <= pclk_q[1] & ~pclk_q[2];
      hfall_q   <= ~href_q[1] & href_q[2];
      vfall_q   <= ~vsync_q[1] & vsync_q[2];
      vrise_q   <= vsync_q[1] & ~vsync_q[2];
      href_ev_q <= href_q[1];
      byte_q    <= data2_q;
    end
  end

  // Capture FSM with registered strobes, counters and frame status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StWaitFrame;
      hi_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      inc_q         <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      if (inc_q) begin
        x_q   <= x_q + 9'd1;
        inc_q <= 1'b0;
      end
      if (vfall_q) begin
        // Also covers a vsync glitch mid-frame: restart without a frame_done
        frame_start_q <= 1'b1;
        x_q           <= '0;
        y_q           <= '0;
        inc_q         <= 1'b0;
        overflow_q    <= 1'b0;
        state_q       <= StWaitLine;
      end else if (state_q != StWaitFrame) begin
        if (vrise_q) begin
          frame_done_q <= 1'b1;
          frame_ok_q   <= (y_q == YMax) && !overflow_q;
          state_q      <= StWaitFrame;
        end else if (prise_q && href_ev_q) begin
          // hfall needs href low, so it can never coincide with a valid byte
          if (state_q == StWaitLine) begin
            hi_q    <= byte_q;
            state_q <= StByteLo;
          end else begin
            if (x_eff < XMax && y_q < YMax) begin
              pixel_data_q  <= {hi_q, byte_q};
              pixel_valid_q <= 1'b1;
              inc_q         <= 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
            state_q <= StWaitLine;
          end
        end else if (hfall_q) begin
          if (state_q == StByteLo) overflow_q <= 1'b1;
          if (x_eff != 9'd0 && y_q < YMax) y_q <= y_q + 8'd1;
          x_q     <= '0;
          inc_q   <= 1'b0;
          state_q <= StWaitLine;
        end
      end
    end
  end

  assign cam.pixel_data  = pixel_data_q;
  assign cam.pixel_valid = pixel_valid_q;
  assign cam.pixel_x     = x_q[7:0];
  assign cam.pixel_y     = y_q[6:0];
  assign cam.frame_start = frame_start_q;
  assign cam.frame_done  = frame_done_q;
  assign cam.frame_ok    = frame_ok_q;
  assign cam.overflow    = overflow_q;

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture: stimulus pushes expected events, a monitor pops and compares.
module tb_cam_capture;

  // Full line width; short frame height keeps whole frames within the cycle budget.
  localparam int unsigned W = 160;
  localparam int unsigned H = 4;

  logic clk;
  logic reset;
  cam_capture_if cam ();

  cam_capture #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .reset (reset),
    .cam   (cam)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 pixel, 1 frame_start, 2 frame_done
    logic [15:0] data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic        ok;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Bench-side model of the capture counters
  int   m_x = 0;
  int   m_y = 0;
  bit   m_ovf = 1'b0;
  bit   m_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic push_evt(input int kind, input logic [15:0] d, input int x, input int y,
                          input bit ok, input bit ovf);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.x    = 8'(x);
    e.y    = 7'(y);
    e.ok   = ok;
    e.ovf  = ovf;
    sb.push_back(e);
  endtask

  // Monitor: every strobe the DUT presents must match the head of the scoreboard
  always @(negedge clk) begin
    if (cam.pixel_valid || cam.frame_start || cam.frame_done) begin
      int   kind;
      exp_t e;
      bit   bad;
      checks++;
      kind = cam.pixel_valid ? 0 : (cam.frame_start ? 1 : 2);
      if ((32'(cam.pixel_valid) + 32'(cam.frame_start) + 32'(cam.frame_done)) > 1) begin
        failures++;
        $display("FAIL strobe_exclusive pv=%0b fs=%0b fd=%0b exp=one_hot",
                 cam.pixel_valid, cam.frame_start, cam.frame_done);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event kind=%0d x=%0d y=%0d exp=none", kind,
                 cam.pixel_x, cam.pixel_y);
      end else begin
        e   = sb.pop_front();
        bad = (kind != e.kind);
        if (!bad && kind == 0)
          bad = (cam.pixel_data !== e.data) || (cam.pixel_x !== e.x) || (cam.pixel_y !== e.y);
        if (!bad && kind == 1)
          bad = (cam.pixel_x !== 8'd0) || (cam.pixel_y !== 7'd0) || (cam.overflow !== 1'b0);
        if (!bad && kind == 2)
          bad = (cam.frame_ok !== e.ok) || (cam.overflow !== e.ovf);
        if (bad) begin
          failures++;
          $display("FAIL event got kind=%0d data=%h x=%0d y=%0d ok=%0b ovf=%0b exp kind=%0d data=%h x=%0d y=%0d ok=%0b ovf=%0b",
                   kind, cam.pixel_data, cam.pixel_x, cam.pixel_y, cam.frame_ok, cam.overflow,
                   e.kind, e.data, e.x, e.y, e.ok, e.ovf);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    cam.camera_data = b;
    cam.pclk = 1'b1;
    repeat (2) @(negedge clk);
    cam.pclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Bytes start + step*i; pairs are modelled as they are sent
  task automatic send_line(input int n, input logic [7:0] start, input logic [7:0] step);
    logic [7:0] b, prev;
    prev = '0;
    cam.href = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      b = start + 8'(step * i);
      if ((i % 2) == 1 && m_active) begin
        if (m_x < int'(W) && m_y < int'(H)) begin
          push_evt(0, {prev, b}, m_x, m_y, 1'b0, 1'b0);
          m_x++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      send_byte(b);
      prev = b;
    end
    end_line(n);
  endtask

  task automatic end_line(input int n);
    if ((n % 2) == 1 && m_active) m_ovf = 1'b1;
    cam.href = 1'b0;
    repeat (4) @(negedge clk);
    if (m_active && m_x > 0 && m_y < int'(H)) m_y++;
    m_x = 0;
  endtask

  task automatic vsync_fall();
    cam.vsync = 1'b0;
    push_evt(1, '0, 0, 0, 1'b0, 1'b0);
    m_x = 0; m_y = 0; m_ovf = 1'b0; m_active = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic vsync_rise();
    cam.vsync = 1'b1;
    if (m_active) push_evt(2, '0, 0, 0, (m_y == int'(H)) && !m_ovf, m_ovf);
    m_active = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cam.camera_data = '0;
    cam.pclk  = 1'b0;
    cam.href  = 1'b0;
    cam.vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pixel_valid", 32'(cam.pixel_valid), 0);
    chk("rst_pixel_data", 32'(cam.pixel_data), 0);
    chk("rst_xy", {cam.pixel_x, 1'b0, cam.pixel_y}, 0);
    chk("rst_flags", {cam.frame_start, cam.frame_done, cam.frame_ok, cam.overflow}, 0);
    reset = 1'b1;
    repeat (6) @(negedge clk);

    // Frame start latency: pulse three clk after the edge that first samples vsync=0
    cam.vsync = 1'b0;
    push_evt(1, '0, 0, 0, 1'b0, 1'b0);
    m_x = 0; m_y = 0; m_ovf = 1'b0; m_active = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("fs_latency_%0d", k), 32'(cam.frame_start), (k == 4) ? 1 : 0);
    end
    repeat (4) @(negedge clk);

    // Overlong line (161 pairs + orphan), then three short lines: frame_ok=0
    send_line(323, 8'h01, 8'h01);
    chk("ovf_after_long_line", 32'(cam.overflow), 1);
    for (int l = 0; l < 3; l++) send_line(8, 8'h20, 8'h11);
    vsync_rise();

    // Short frame: overflow cleared by the new start, too few lines
    vsync_fall();
    for (int l = 0; l < 3; l++) send_line(8, 8'h40, 8'h07);
    vsync_rise();

    // One line too many: extra line gives no strobes and sets overflow
    vsync_fall();
    for (int l = 0; l < 5; l++) send_line(6, 8'h90, 8'h05);
    vsync_rise();

    // Full frame, first line 0x60 step 3 gives 0x6063, 0x6669, ...
    vsync_fall();
    send_line(320, 8'h60, 8'h03);
    chk("y_after_line0", 32'(cam.pixel_y), 1);
    for (int l = 0; l < 3; l++) send_line(320, 8'h00, 8'h01);
    vsync_rise();
    chk("frame_ok_held", 32'(cam.frame_ok), 1);

    // Mid-line asynchronous reset at pixel_x=57
    vsync_fall();
    cam.href = 1'b1;
    repeat (2) @(negedge clk);
    begin
      logic [7:0] b, prev;
      prev = '0;
      for (int i = 0; i < 115; i++) begin
        b = 8'hC0 + 8'(i);
        if ((i % 2) == 1) begin
          push_evt(0, {prev, b}, m_x, m_y, 1'b0, 1'b0);
          m_x++;
        end
        send_byte(b);
        prev = b;
      end
    end
    chk("x_before_reset", 32'(cam.pixel_x), 57);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_x", 32'(cam.pixel_x), 0);
    chk("async_rst_data", 32'(cam.pixel_data), 0);
    chk("async_rst_ok", 32'(cam.frame_ok), 0);
    m_active = 1'b0;
    cam.href = 1'b0;
    cam.pclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    // vsync still low: this line must produce nothing
    send_line(8, 8'h33, 8'h01);
    vsync_rise();
    vsync_fall();

    // Pixel latency: strobe three clk after the edge that first samples pclk=1
    cam.href = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'hA5);
    cam.camera_data = 8'h5A;
    push_evt(0, 16'hA55A, 0, 0, 1'b0, 1'b0);
    m_x = 1;
    cam.pclk = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) cam.pclk = 1'b0;
      chk($sformatf("pv_latency_%0d", k), 32'(cam.pixel_valid), (k == 4) ? 1 : 0);
    end
    end_line(2);
    vsync_rise();

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
